// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the WISC write-back stage:
//   - write-data source select codes (WB_SRC_*)
//   - halt drain state encoding (wb_state_e)
// ---------------------------------------------------------------------------
package wb_pkg;

    // Write-data source select codes driven on in_sel.
    localparam int unsigned WB_SRC_MEM  = 0;
    localparam int unsigned WB_SRC_ALU  = 1;
    localparam int unsigned WB_SRC_PC   = 2;
    localparam int unsigned WB_SRC_COND = 3;

    // Halt drain state machine.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_src_mux.sv
// ---------------------------------------------------------------------------
// wb_src_mux
// Combinational NUM_SRC-way write-data source select.
// Ports:
//   sel_i       in   SEL_W   source select (WB_SRC_* codes)
//   mem_i       in   DATA_W  memory read data
//   alu_i       in   DATA_W  ALU result
//   pc_inc_i    in   DATA_W  PC+2
//   cond_i      in   1       condition bit (zero-extended)
//   data_o      out  DATA_W  selected data, 0 when the select is illegal
//   illegal_o   out  1       select code not below NUM_SRC
// ---------------------------------------------------------------------------
module wb_src_mux
    import wb_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int unsigned NUM_SRC = 4,
    parameter int          SEL_W   = 2
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] pc_inc_i,
    input  logic              cond_i,
    output logic [DATA_W-1:0] data_o,
    output logic              illegal_o
);

    logic [31:0] sel_ext;

    assign sel_ext = 32'(sel_i);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if leaves it unassigned and a latch is never inferred.
    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        if (sel_ext >= NUM_SRC) begin
            illegal_o = 1'b1;
        end else begin
            case (sel_ext)
                WB_SRC_MEM:  data_o = mem_i;
                WB_SRC_ALU:  data_o = alu_i;
                WB_SRC_PC:   data_o = pc_inc_i;
                WB_SRC_COND: data_o = {{(DATA_W-1){1'b0}}, cond_i};
                default:     data_o = '0;
            endcase
        end
    end

endmodule : wb_src_mux

// File: rtl/wb_pipe_stage.sv
// ---------------------------------------------------------------------------
// wb_pipe_stage
// WISC write-back stage: MEM/WB pipeline register with valid/stall handshake,
// write-data source select, forwarding tap, halt drain FSM and a wrapping
// retired-instruction counter.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           memory-stage handshake
//   in_sel, in_mem_data,
//   in_alu_data, in_pc_inc,
//   in_cond                       write-data sources and select
//   in_wr, in_we, in_halt         destination, write enable, HALT marker
//   flush                         kill the instruction offered this cycle
//   stall                         register-file port busy, hold register
//   we_out, wr_out, wd_out        register-file write port
//   fwd_valid, fwd_wr, fwd_data   bypass tap (pending write)
//   halted                        HALT has retired (sticky until reset)
//   retire_count                  retired instructions, wrapping
//   err                           sticky error
// ---------------------------------------------------------------------------
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          REG_W   = 3,
    parameter int unsigned NUM_SRC = 4,
    parameter int          SEL_W   = 2,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_pc_inc,
    input  logic              in_cond,
    input  logic [REG_W-1:0]  in_wr,
    input  logic              in_we,
    input  logic              in_halt,
    input  logic              flush,
    input  logic              stall,
    output logic              we_out,
    output logic [REG_W-1:0]  wr_out,
    output logic [DATA_W-1:0] wd_out,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_wr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count,
    output logic              err
);

    wb_state_e         state_q, state_d;
    logic              occ_q,   occ_d;
    logic              we_q,    we_d;
    logic              halt_q,  halt_d;
    logic              err_q,   err_d;
    logic [REG_W-1:0]  wr_q,    wr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] src_data;
    logic              src_illegal;
    logic              accept;
    logic              retire;

    wb_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .sel_i     (in_sel),
        .mem_i     (in_mem_data),
        .alu_i     (in_alu_data),
        .pc_inc_i  (in_pc_inc),
        .cond_i    (in_cond),
        .data_o    (src_data),
        .illegal_o (src_illegal)
    );

    // A full register can take a new instruction in the same cycle it retires,
    // so only a full-and-stalled register blocks the memory stage.
    assign in_ready = (state_q == RUN) && (!occ_q || !stall);
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = occ_q && !stall;

    // Stage register, counter and sticky error.
    always_comb begin
        occ_d   = occ_q;
        we_d    = we_q;
        halt_d  = halt_q;
        wr_d    = wr_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = err_q;

        if (accept) begin
            occ_d  = 1'b1;
            // HALT never writes the register file, whatever in_we says.
            we_d   = in_we && !in_halt;
            halt_d = in_halt;
            wr_d   = in_wr;
            data_d = src_data;
        end else if (retire) begin
            occ_d = 1'b0;
        end

        if (retire) begin
            count_d = count_q + CNT_W'(1);
        end

        if ((accept && src_illegal) || (in_valid && state_q != RUN)) begin
            err_d = 1'b1;
        end
    end

    // Halt drain FSM next state. In DRAIN the only occupant can be the HALT,
    // since in_ready is low there; halt_q is still checked for clarity.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && in_halt) state_d = DRAIN;
            DRAIN:   if (retire && halt_q)  state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            occ_q   <= 1'b0;
            we_q    <= 1'b0;
            halt_q  <= 1'b0;
            wr_q    <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            we_q    <= we_d;
            halt_q  <= halt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign we_out       = occ_q && we_q && !stall;
    assign wr_out       = wr_q;
    assign wd_out       = data_q;
    assign fwd_valid    = occ_q && we_q;
    assign fwd_wr       = wr_q;
    assign fwd_data     = data_q;
    assign halted       = (state_q == HALTED);
    assign retire_count = count_q;
    assign err          = err_q;

endmodule : wb_pipe_stage
